dm_port_arbiter: RTL and testbench

//   Shares the single data-memory port (DM_Address/DM_enable/DM_Write_Data/DM_Read_Data) between two requesters.
//   The CPU core issues lw/sw; a DMA/loader engine moves bursts of words.

---
 rtl/dm_port_arbiter.sv | 132 +++++++++++++
 tb/tb_dm_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU core and a DMA engine.
// DMA bursts hold the port for up to MAX_BURST beats; a low cpu_gnt is the CPU stall.
module dm_port_arbiter #(
  parameter int bit_size  = 32,
  parameter int mem_size  = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  // CPU requester
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [mem_size-1:0] cpu_addr,
  input  logic [bit_size-1:0] cpu_wdata,
  output logic                cpu_gnt,
  output logic                cpu_rvalid,
  output logic [bit_size-1:0] cpu_rdata,
  // DMA requester
  input  logic                dma_req,
  input  logic                dma_we,
  input  logic                dma_last,
  input  logic [mem_size-1:0] dma_addr,
  input  logic [bit_size-1:0] dma_wdata,
  output logic                dma_gnt,
  output logic                dma_rvalid,
  output logic [bit_size-1:0] dma_rdata,
  // data memory port
  output logic [mem_size-1:0] DM_Address,
  output logic                DM_enable,
  output logic [bit_size-1:0] DM_Write_Data,
  input  logic [bit_size-1:0] DM_Read_Data,
  // debug: current owner (0 = idle, 1 = cpu, 2 = dma)
  output logic [1:0]          dbg_owner
);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  // beat_cnt holds the number of beats already taken in the current burst
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  owner_t           owner, owner_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic             last_dma;

  // Handshake: x_req is the requester's valid, x_gnt its ready. A beat moves on the
  // rising edge where both are high; the requester keeps we/addr/wdata stable until then.
  assign cpu_gnt   = (owner == OWN_CPU) && cpu_req;
  assign dma_gnt   = (owner == OWN_DMA) && dma_req;
  assign dbg_owner = owner;

  always_comb begin
    DM_Address    = '0;
    DM_enable     = 1'b0;
    DM_Write_Data = '0;
    if (cpu_gnt) begin
      DM_Address    = cpu_addr;
      DM_enable     = cpu_we;
      DM_Write_Data = cpu_wdata;
    end else if (dma_gnt) begin
      DM_Address    = dma_addr;
      DM_enable     = dma_we;
      DM_Write_Data = dma_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner    <= OWN_IDLE;
      beat_cnt <= '0;
    end else begin
      owner    <= owner_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // beat_cnt is zero outside DMA ownership, so every DMA entry starts a fresh burst
  always_comb begin
    owner_nxt    = owner;
    beat_cnt_nxt = '0;
    case (owner)
      OWN_IDLE: begin
        if (cpu_req && (!dma_req || last_dma)) owner_nxt = OWN_CPU;
        else if (dma_req)                      owner_nxt = OWN_DMA;
      end
      OWN_CPU: begin
        if (dma_req)       owner_nxt = OWN_DMA;
        else if (!cpu_req) owner_nxt = OWN_IDLE;
      end
      OWN_DMA: begin
        if (!dma_req || dma_last || (beat_cnt == CNT_LAST)) begin
          if (cpu_req)      owner_nxt = OWN_CPU;
          else if (dma_req) owner_nxt = OWN_DMA;
          else              owner_nxt = OWN_IDLE;
        end else begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
        end
      end
      default: owner_nxt = OWN_IDLE;
    endcase
  end

  // last_dma reset to 1 so the CPU wins the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_dma <= 1'b1;
    end else if (cpu_gnt) begin
      last_dma <= 1'b0;
    end else if (dma_gnt) begin
      last_dma <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      cpu_rvalid <= cpu_gnt && !cpu_we;
      dma_rvalid <= dma_gnt && !dma_we;
      if (cpu_gnt && !cpu_we) cpu_rdata <= DM_Read_Data;
      if (dma_gnt && !dma_we) dma_rdata <= DM_Read_Data;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: drivers push expected grants/read data into
// queues, a negedge monitor pops and compares; a behavioural DM sits on the port.
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_last, dma_gnt, dma_rvalid;
  logic [15:0] dma_addr;
  logic [31:0] dma_wdata, dma_rdata;
  logic [15:0] DM_Address;
  logic        DM_enable;
  logic [31:0] DM_Write_Data, DM_Read_Data;
  logic [1:0]  dbg_owner;

  logic [31:0] dm_mem [0:65535];

  logic [17:0] gnt_q[$];      // {side(1=dma), we, addr}
  logic [31:0] cpu_rd_q[$];
  logic [31:0] dma_rd_q[$];

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int cpu_gnt_cyc, dma_gnt_cyc, rel_cyc, first_cyc, d2_cyc;

  dm_port_arbiter #(.bit_size(32), .mem_size(16), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_last(dma_last), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .DM_Address(DM_Address), .DM_enable(DM_enable), .DM_Write_Data(DM_Write_Data),
    .DM_Read_Data(DM_Read_Data), .dbg_owner(dbg_owner)
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign DM_Read_Data = dm_mem[DM_Address];
  always @(posedge clk) if (DM_enable) dm_mem[DM_Address] <= DM_Write_Data;

  function automatic logic [31:0] init_val(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic cpu_beat(input logic we, input logic [15:0] addr, input logic [31:0] wdata);
    bit got = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (cpu_gnt) begin got = 1'b1; cpu_gnt_cyc = cyc; end
    end
    if (!got) begin
      n_vec++; n_fail++;
      $display("FAIL cpu_gnt_timeout: addr %0d got no grant, required grant within 64 cycles", addr);
    end else begin
      @(posedge clk); #1;
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic dma_beat(input logic we, input logic last, input logic [15:0] addr,
                          input logic [31:0] wdata);
    bit got = 1'b0;
    dma_req = 1'b1; dma_we = we; dma_last = last; dma_addr = addr; dma_wdata = wdata;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (dma_gnt) begin got = 1'b1; dma_gnt_cyc = cyc; end
    end
    if (!got) begin
      n_vec++; n_fail++;
      $display("FAIL dma_gnt_timeout: addr %0d got no grant, required grant within 64 cycles", addr);
    end else begin
      @(posedge clk); #1;
    end
    dma_req = 1'b0; dma_we = 1'b0; dma_last = 1'b0;
  endtask

  task automatic idle_gap();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (cpu_gnt || dma_gnt) begin
        check("gnt_exclusive", 64'(cpu_gnt & dma_gnt), 64'd0);
        if (gnt_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL grant_unexpected: got cpu_gnt=%0b dma_gnt=%0b, required no grant", cpu_gnt, dma_gnt);
        end else if (cpu_gnt) begin
          check("grant_seq", 64'({1'b0, cpu_we, cpu_addr}), 64'(gnt_q.pop_front()));
          check("dm_mux_cpu", 64'({DM_Address, DM_enable, DM_Write_Data}),
                64'({cpu_addr, cpu_we, cpu_wdata}));
        end else begin
          check("grant_seq", 64'({1'b1, dma_we, dma_addr}), 64'(gnt_q.pop_front()));
          check("dm_mux_dma", 64'({DM_Address, DM_enable, DM_Write_Data}),
                64'({dma_addr, dma_we, dma_wdata}));
        end
      end else begin
        check("dm_idle", 64'({DM_Address, DM_enable, DM_Write_Data}), 64'd0);
      end
      if (cpu_rvalid) begin
        if (cpu_rd_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL cpu_rvalid_unexpected: got rdata %h, required no rvalid", cpu_rdata);
        end else check("cpu_rdata", 64'(cpu_rdata), 64'(cpu_rd_q.pop_front()));
      end
      if (dma_rvalid) begin
        if (dma_rd_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL dma_rvalid_unexpected: got rdata %h, required no rvalid", dma_rdata);
        end else check("dma_rdata", 64'(dma_rdata), 64'(dma_rd_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, required completion earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 65536; i++) dm_mem[i] = init_val(i);
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd0; cpu_wdata = '0;
    dma_req = 1'b1; dma_we = 1'b0; dma_last = 1'b1; dma_addr = 16'd1; dma_wdata = '0;

    // reset held with both requests up
    repeat (3) @(negedge clk);
    check("rst_gnt", 64'({cpu_gnt, dma_gnt}), 64'd0);
    check("rst_dm", 64'({DM_Address, DM_enable, DM_Write_Data}), 64'd0);
    check("rst_rvalid", 64'({cpu_rvalid, dma_rvalid}), 64'd0);
    check("rst_rdata", 64'({cpu_rdata, dma_rdata}), 64'd0);
    check("rst_owner", 64'(dbg_owner), 64'd0);
    gnt_q.push_back({1'b0, 1'b0, 16'd0});
    gnt_q.push_back({1'b1, 1'b0, 16'd1});
    cpu_rd_q.push_back(32'hC0DE_0000);
    dma_rd_q.push_back(32'hC0DE_0001);
    rel_cyc = cyc;
    rst = 1'b1;
    fork
      cpu_beat(1'b0, 16'd0, 32'd0);
      dma_beat(1'b0, 1'b1, 16'd1, 32'd0);
    join
    check("rst_cpu_first", 64'(cpu_gnt_cyc - rel_cyc), 64'd1);
    check("rst_dma_next", 64'(dma_gnt_cyc - rel_cyc), 64'd2);

    // CPU only: sw then lw to address 5
    idle_gap();
    gnt_q.push_back({1'b0, 1'b1, 16'd5});
    gnt_q.push_back({1'b0, 1'b0, 16'd5});
    cpu_rd_q.push_back(32'hDEAD_BEEF);
    cpu_beat(1'b1, 16'd5, 32'hDEAD_BEEF);
    check("cpu_sw_mem", 64'(dm_mem[5]), 64'h0000_0000_DEAD_BEEF);
    cpu_beat(1'b0, 16'd5, 32'd0);
    @(negedge clk);
    check("cpu_rvalid_pulse", 64'({cpu_rvalid, cpu_rdata}), 64'({1'b1, 32'hDEAD_BEEF}));
    @(negedge clk);
    check("cpu_rvalid_drop", 64'({cpu_rvalid, cpu_rdata}), 64'({1'b0, 32'hDEAD_BEEF}));

    // DMA burst of 6 without dma_last: 4 beats, re-grant, 2 more, no gap
    idle_gap();
    for (int a = 10; a < 16; a++) gnt_q.push_back({1'b1, 1'b1, 16'(a)});
    for (int a = 10; a < 16; a++) begin
      dma_beat(1'b1, 1'b0, 16'(a), 32'h1000_0000 + 32'(a));
      if (a == 10) first_cyc = dma_gnt_cyc;
    end
    check("dma_burst_span", 64'(dma_gnt_cyc - first_cyc), 64'd5);
    for (int a = 10; a < 16; a++) check("dma_burst_mem", 64'(dm_mem[a]), 64'(32'h1000_0000 + 32'(a)));

    // contention: DMA 4 beats, CPU 1 beat, DMA 2 beats, CPU 1 beat
    idle_gap();
    for (int a = 20; a < 24; a++) gnt_q.push_back({1'b1, 1'b1, 16'(a)});
    gnt_q.push_back({1'b0, 1'b1, 16'd30});
    gnt_q.push_back({1'b1, 1'b1, 16'd24});
    gnt_q.push_back({1'b1, 1'b1, 16'd25});
    gnt_q.push_back({1'b0, 1'b1, 16'd31});
    fork
      begin
        for (int a = 20; a < 26; a++) dma_beat(1'b1, 1'b0, 16'(a), 32'h2000_0000 + 32'(a));
      end
      begin
        @(posedge clk); #1;
        cpu_beat(1'b1, 16'd30, 32'h3000_001E);
        cpu_beat(1'b1, 16'd31, 32'h3000_001F);
      end
    join
    check("cont_mem_dma", 64'(dm_mem[25]), 64'h0000_0000_2000_0019);
    check("cont_mem_cpu", 64'(dm_mem[31]), 64'h0000_0000_3000_001F);

    // dma_last on beat 2 with CPU waiting; DMA read of address 10 in the next burst
    idle_gap();
    gnt_q.push_back({1'b1, 1'b1, 16'd40});
    gnt_q.push_back({1'b1, 1'b1, 16'd41});
    gnt_q.push_back({1'b0, 1'b0, 16'd5});
    gnt_q.push_back({1'b1, 1'b0, 16'd10});
    gnt_q.push_back({1'b1, 1'b1, 16'd43});
    cpu_rd_q.push_back(32'hDEAD_BEEF);
    dma_rd_q.push_back(32'h1000_000A);
    fork
      begin
        dma_beat(1'b1, 1'b0, 16'd40, 32'h4000_0028);
        dma_beat(1'b1, 1'b1, 16'd41, 32'h4000_0029);
        d2_cyc = dma_gnt_cyc;
        dma_beat(1'b0, 1'b0, 16'd10, 32'd0);
        dma_beat(1'b1, 1'b1, 16'd43, 32'h4000_002B);
      end
      begin
        @(posedge clk); #1;
        cpu_beat(1'b0, 16'd5, 32'd0);
      end
    join
    check("last_cpu_next", 64'(cpu_gnt_cyc - d2_cyc), 64'd1);
    check("last_mem", 64'(dm_mem[43]), 64'h0000_0000_4000_002B);

    // asynchronous reset in the middle of a DMA write burst
    idle_gap();
    gnt_q.push_back({1'b1, 1'b1, 16'd50});
    gnt_q.push_back({1'b1, 1'b1, 16'd51});
    gnt_q.push_back({1'b1, 1'b1, 16'd52});
    dma_beat(1'b1, 1'b0, 16'd50, 32'h5000_0032);
    dma_beat(1'b1, 1'b0, 16'd51, 32'h5000_0033);
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'd52; dma_wdata = 32'h5000_0034;
    @(negedge clk);
    check("arst_pre_gnt", 64'({dma_gnt, DM_enable}), 64'b11);
    #2;
    rst = 1'b0;
    #1;
    check("arst_gnt_drop", 64'({dma_gnt, DM_enable, dbg_owner}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    dma_req = 1'b0; dma_we = 1'b0;
    check("arst_mem_held", 64'(dm_mem[52]), 64'(init_val(52)));
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("arst_mem_after", 64'(dm_mem[52]), 64'(init_val(52)));
    check("arst_mem_beats", 64'({dm_mem[50], dm_mem[51]}), 64'h5000_0032_5000_0033);

    repeat (3) @(negedge clk);
    check("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
    check("rd_q_drained", 64'(cpu_rd_q.size() + dma_rd_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
